// File: rtl/load_store_unit.sv
// Data-memory initiator: turns one load/store from the memory stage into a req/gnt/rvalid bus transaction.
// Latency: store done 2 cycles after accept, load data 3 cycles after accept (gnt/rvalid at earliest).
// Backpressure: lsu_busy stalls the pipeline while a transaction is outstanding; lsu_valid is ignored while busy.
//
// Ports: pipeline side (lsu_valid, mem_write, funct3, addr, store_data -> lsu_busy, load_data_valid,
// load_data, store_done, misaligned, bus_error); memory side (bus_req, bus_we, bus_addr, bus_wdata,
// bus_be -> bus_gnt, bus_rvalid, bus_rdata).
module load_store_unit #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int TIMEOUT       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     lsu_valid,
    input  logic                     mem_write,
    input  logic [2:0]               funct3,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    store_data,
    output logic                     lsu_busy,
    output logic                     load_data_valid,
    output logic [DATA_WIDTH-1:0]    load_data,
    output logic                     store_done,
    output logic                     misaligned,
    output logic                     bus_error,
    output logic                     bus_req,
    output logic                     bus_we,
    output logic [ADDRESS_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0]    bus_wdata,
    output logic [3:0]               bus_be,
    input  logic                     bus_gnt,
    input  logic                     bus_rvalid,
    input  logic [DATA_WIDTH-1:0]    bus_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT_R = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     is_store_q, is_store_d;
    logic [2:0]               funct3_q, funct3_d;
    logic [1:0]               off_q, off_d;
    logic                     busy_q, busy_d;
    logic                     load_data_valid_q, load_data_valid_d;
    logic [DATA_WIDTH-1:0]    load_data_q, load_data_d;
    logic                     store_done_q, store_done_d;
    logic                     misaligned_q, misaligned_d;
    logic                     bus_error_q, bus_error_d;
    logic                     bus_req_q, bus_req_d;
    logic                     bus_we_q, bus_we_d;
    logic [ADDRESS_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_WIDTH-1:0]    bus_wdata_q, bus_wdata_d;
    logic [3:0]               bus_be_q, bus_be_d;

    // Incoming request decode: legality, alignment and store lane placement.
    // funct3[1:0] encodes the size (00 byte, 01 half, 10 word); 11 is always illegal.
    logic                  req_legal;
    logic                  req_aligned;
    logic [3:0]            req_be;
    logic [DATA_WIDTH-1:0] req_wdata;

    always_comb begin
        req_legal = 1'b0;
        if (mem_write) begin
            req_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        end else begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_legal = 1'b1;
                default:                                 req_legal = 1'b0;
            endcase
        end

        case (funct3[1:0])
            2'b01:   req_aligned = ~addr[0];
            2'b10:   req_aligned = (addr[1:0] == 2'b00);
            default: req_aligned = 1'b1;
        endcase

        case (funct3[1:0])
            2'b00: begin
                req_be    = 4'b0001 << addr[1:0];
                req_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                req_be    = addr[1] ? 4'b1100 : 4'b0011;
                req_wdata = {2{store_data[15:0]}};
            end
            default: begin
                req_be    = 4'b1111;
                req_wdata = store_data;
            end
        endcase
    end

    // Read response extraction; sign comes from the selected byte/half, not bit 31 of the word.
    logic [DATA_WIDTH-1:0] rdata_shift;
    logic [7:0]            rbyte;
    logic [15:0]           rhalf;
    logic [DATA_WIDTH-1:0] rext;

    always_comb begin
        rdata_shift = bus_rdata >> {off_q, 3'b000};
        rbyte       = rdata_shift[7:0];
        rhalf       = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (funct3_q)
            3'b000:  rext = {{24{rbyte[7]}}, rbyte};
            3'b100:  rext = {24'd0, rbyte};
            3'b001:  rext = {{16{rhalf[15]}}, rhalf};
            3'b101:  rext = {16'd0, rhalf};
            default: rext = bus_rdata;
        endcase
    end

    // Next-state and registered-output logic. Pulses default low; bus fields hold their last value.
    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        is_store_d        = is_store_q;
        funct3_d          = funct3_q;
        off_d             = off_q;
        load_data_valid_d = 1'b0;
        load_data_d       = load_data_q;
        store_done_d      = 1'b0;
        misaligned_d      = 1'b0;
        bus_error_d       = 1'b0;
        bus_req_d         = bus_req_q;
        bus_we_d          = bus_we_q;
        bus_addr_d        = bus_addr_q;
        bus_wdata_d       = bus_wdata_q;
        bus_be_d          = bus_be_q;

        case (state_q)
            S_IDLE: begin
                if (lsu_valid) begin
                    if (!req_legal || !req_aligned) begin
                        misaligned_d = 1'b1;
                    end else begin
                        state_d     = S_REQ;
                        cnt_d       = '0;
                        is_store_d  = mem_write;
                        funct3_d    = funct3;
                        off_d       = addr[1:0];
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_write;
                        bus_addr_d  = {addr[ADDRESS_WIDTH-1:2], 2'b00};
                        bus_wdata_d = req_wdata;
                        bus_be_d    = req_be;
                    end
                end
            end
            S_REQ: begin
                if (bus_gnt) begin
                    bus_req_d = 1'b0;
                    if (is_store_q) begin
                        state_d      = S_DONE;
                        store_done_d = 1'b1;
                    end else begin
                        state_d = S_WAIT_R;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    bus_error_d = 1'b1;
                    bus_req_d   = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_R: begin
                if (bus_rvalid) begin
                    load_data_d       = rext;
                    load_data_valid_d = 1'b1;
                    state_d           = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    bus_error_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= S_IDLE;
            cnt_q             <= '0;
            is_store_q        <= 1'b0;
            funct3_q          <= 3'd0;
            off_q             <= 2'd0;
            busy_q            <= 1'b0;
            load_data_valid_q <= 1'b0;
            load_data_q       <= '0;
            store_done_q      <= 1'b0;
            misaligned_q      <= 1'b0;
            bus_error_q       <= 1'b0;
            bus_req_q         <= 1'b0;
            bus_we_q          <= 1'b0;
            bus_addr_q        <= '0;
            bus_wdata_q       <= '0;
            bus_be_q          <= 4'd0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            is_store_q        <= is_store_d;
            funct3_q          <= funct3_d;
            off_q             <= off_d;
            busy_q            <= busy_d;
            load_data_valid_q <= load_data_valid_d;
            load_data_q       <= load_data_d;
            store_done_q      <= store_done_d;
            misaligned_q      <= misaligned_d;
            bus_error_q       <= bus_error_d;
            bus_req_q         <= bus_req_d;
            bus_we_q          <= bus_we_d;
            bus_addr_q        <= bus_addr_d;
            bus_wdata_q       <= bus_wdata_d;
            bus_be_q          <= bus_be_d;
        end
    end

    assign lsu_busy        = busy_q;
    assign load_data_valid = load_data_valid_q;
    assign load_data       = load_data_q;
    assign store_done      = store_done_q;
    assign misaligned      = misaligned_q;
    assign bus_error       = bus_error_q;
    assign bus_req         = bus_req_q;
    assign bus_we          = bus_we_q;
    assign bus_addr        = bus_addr_q;
    assign bus_wdata       = bus_wdata_q;
    assign bus_be          = bus_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: drives loads/stores with directed and random bus timing,
// checks every cycle against an arithmetic reference of the access rules.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_load_store_unit;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lsu_valid, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        lsu_busy, load_data_valid, store_done, misaligned, bus_error;
    logic [31:0] load_data;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] last_load = 32'd0;

    load_store_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .lsu_valid(lsu_valid), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .store_data(store_data), .lsu_busy(lsu_busy),
        .load_data_valid(load_data_valid), .load_data(load_data), .store_done(store_done),
        .misaligned(misaligned), .bus_error(bus_error), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_gnt(bus_gnt),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model: access rules as plain arithmetic ----------------
    function automatic bit m_legal(input bit we, input logic [2:0] f3);
        if (we) return (f3 <= 3'd2);
        return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    function automatic int m_size(input logic [2:0] f3);
        return 1 << (int'(f3) % 4);
    endfunction

    function automatic bit m_ok(input bit we, input logic [2:0] f3, input logic [31:0] a);
        return m_legal(we, f3) && ((a % m_size(f3)) == 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int sz = m_size(f3);
        int o  = int'(a % 4);
        return 4'(((1 << sz) - 1) << o);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        int                sz  = m_size(f3);
        longint unsigned   v   = longint'(sd) % (64'd1 << (8 * sz));
        longint unsigned   rep = 0;
        for (int i = 0; i < 4 / sz; i++) rep = rep + (v << (8 * sz * i));
        return rep[31:0];
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int              sz = m_size(f3);
        longint unsigned v  = (longint'(rd) >> (8 * (a % 4))) % (64'd1 << (8 * sz));
        if (f3 < 3'd4 && sz < 4 && v >= (64'd1 << (8 * sz - 1)))
            v = v + ((64'd1 << 32) - (64'd1 << (8 * sz)));
        return v[31:0];
    endfunction

    // ---------------- one transaction, checked cycle by cycle ----------------
    // g: REQ cycles without gnt before gnt; r: WAIT_R cycles before rvalid.
    // noise: toggle rvalid with junk data while it must be ignored.
    task automatic run_txn(input bit we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input int g, input int r,
                           input logic [31:0] rd, input bit noise);
        bit          timed_out = 0;
        logic [31:0] exp_ld;
        lsu_valid = 1'b1; mem_write = we; funct3 = f3; addr = a; store_data = sd;
        step();
        if (!m_ok(we, f3, a)) begin
            n_cmp++;
            if ({misaligned, bus_req, lsu_busy, load_data} !== {1'b1, 1'b0, 1'b0, last_load}) begin
                n_fail++;
                $display("FAIL reject a=%h f3=%b we=%b: got mis/req/busy/ld=%b%b%b/%h want 100/%h",
                         a, f3, we, misaligned, bus_req, lsu_busy, load_data, last_load);
            end
            lsu_valid = 1'b0;
            step();
            n_cmp++;
            if ({misaligned, bus_req, lsu_busy} !== 3'b000) begin
                n_fail++;
                $display("FAIL reject_pulse_end: got mis/req/busy=%b%b%b want 000", misaligned, bus_req, lsu_busy);
            end
            return;
        end
        // REQ phase
        for (int k = 0; k <= TMO; k++) begin
            n_cmp++;
            if ({bus_req, lsu_busy, bus_we, bus_addr} !== {1'b1, 1'b1, we, a & 32'hFFFF_FFFC}) begin
                n_fail++;
                $display("FAIL req_cycle%0d: got req/busy/we/addr=%b%b%b/%h want 11%b/%h",
                         k, bus_req, lsu_busy, bus_we, bus_addr, we, a & 32'hFFFF_FFFC);
            end
            if (we) begin
                n_cmp++;
                if ({bus_be, bus_wdata} !== {m_be(f3, a), m_wdata(f3, sd)}) begin
                    n_fail++;
                    $display("FAIL store_lanes a=%h f3=%b: got be/wdata=%b/%h want %b/%h",
                             a, f3, bus_be, bus_wdata, m_be(f3, a), m_wdata(f3, sd));
                end
            end
            // request fields change while busy; the DUT must keep using the latched ones
            lsu_valid = 1'b1; addr = $urandom; funct3 = 3'($urandom); mem_write = 1'($urandom);
            bus_rvalid = noise ? 1'($urandom) : 1'b0;
            bus_rdata  = $urandom;
            if (k == g) begin
                bus_gnt = 1'b1;
                step();
                bus_gnt = 1'b0;
                break;
            end
            if (k == TMO - 1) begin
                step();
                timed_out = 1;
                break;
            end
            step();
        end
        bus_rvalid = 1'b0;
        if (!timed_out && !we) begin
            // WAIT_R phase
            for (int k = 0; k <= TMO; k++) begin
                n_cmp++;
                if ({bus_req, lsu_busy, load_data_valid, load_data} !== {1'b0, 1'b1, 1'b0, last_load}) begin
                    n_fail++;
                    $display("FAIL wait_cycle%0d: got req/busy/ldv/ld=%b%b%b/%h want 010/%h",
                             k, bus_req, lsu_busy, load_data_valid, load_data, last_load);
                end
                if (k == r) begin
                    bus_rvalid = 1'b1; bus_rdata = rd;
                    step();
                    bus_rvalid = 1'b0;
                    break;
                end
                if (k == TMO - 1) begin
                    step();
                    timed_out = 1;
                    break;
                end
                step();
            end
        end
        if (timed_out) begin
            n_cmp++;
            if ({bus_error, bus_req, lsu_busy, load_data_valid, store_done, load_data} !==
                {5'b10000, last_load}) begin
                n_fail++;
                $display("FAIL timeout: got err/req/busy/ldv/sd/ld=%b%b%b%b%b/%h want 10000/%h",
                         bus_error, bus_req, lsu_busy, load_data_valid, store_done, load_data, last_load);
            end
            lsu_valid = 1'b0;
            step();
            n_cmp++;
            if ({bus_error, lsu_busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL timeout_pulse_end: got err/busy=%b%b want 00", bus_error, lsu_busy);
            end
            return;
        end
        exp_ld = we ? last_load : m_load(f3, a, rd);
        n_cmp++;
        if ({bus_req, lsu_busy, store_done, load_data_valid, load_data} !== {2'b01, we, ~we, exp_ld}) begin
            n_fail++;
            $display("FAIL done a=%h f3=%b we=%b: got req/busy/sd/ldv/ld=%b%b%b%b/%h want 01%b%b/%h",
                     a, f3, we, bus_req, lsu_busy, store_done, load_data_valid, load_data, we, ~we, exp_ld);
        end
        lsu_valid = 1'b0;
        step();
        n_cmp++;
        if ({lsu_busy, store_done, load_data_valid, load_data} !== {3'b000, exp_ld}) begin
            n_fail++;
            $display("FAIL idle_after_done: got busy/sd/ldv/ld=%b%b%b/%h want 000/%h",
                     lsu_busy, store_done, load_data_valid, load_data, exp_ld);
        end
        last_load = exp_ld;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; lsu_valid = 1'b0; mem_write = 1'b0; funct3 = 3'd0; addr = 32'd0;
        store_data = 32'd0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
        #12;
        n_cmp++;
        if ({lsu_busy, load_data_valid, load_data, store_done, misaligned, bus_error, bus_req,
             bus_we, bus_addr, bus_wdata, bus_be} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b req=%b ld=%h addr=%h wdata=%h be=%b want all zero",
                     lsu_busy, bus_req, load_data, bus_addr, bus_wdata, bus_be);
        end
        @(negedge clk) rst_n = 1'b1;
        step();
        n_cmp++;
        if ({lsu_busy, bus_req, misaligned} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy/req/mis=%b%b%b want 000", lsu_busy, bus_req, misaligned);
        end
    endtask

    task automatic test_store_sb();
        run_txn(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'd0, 1'b0);
        run_txn(1'b1, 3'b001, 32'h0000_2002, 32'h1234_BEEF, 1, 0, 32'd0, 1'b0);
        run_txn(1'b1, 3'b010, 32'h0000_3000, 32'hCAFE_F00D, 2, 0, 32'd0, 1'b0);
    endtask

    task automatic test_loads();
        run_txn(1'b0, 3'b000, 32'h0000_0002, 32'd0, 0, 0, 32'h0080_1234, 1'b0);
        n_cmp++;
        if (load_data !== 32'hFFFF_FF80) begin
            n_fail++; $display("FAIL lb_value: got %h want ffffff80", load_data);
        end
        run_txn(1'b0, 3'b100, 32'h0000_0002, 32'd0, 0, 0, 32'h0080_1234, 1'b0);
        n_cmp++;
        if (load_data !== 32'h0000_0080) begin
            n_fail++; $display("FAIL lbu_value: got %h want 00000080", load_data);
        end
        run_txn(1'b0, 3'b001, 32'h0000_0006, 32'd0, 0, 0, 32'h8001_FFFF, 1'b1);
        n_cmp++;
        if (load_data !== 32'hFFFF_8001) begin
            n_fail++; $display("FAIL lh_value: got %h want ffff8001", load_data);
        end
        run_txn(1'b0, 3'b101, 32'h0000_0006, 32'd0, 0, 0, 32'h8001_FFFF, 1'b1);
        n_cmp++;
        if (load_data !== 32'h0000_8001) begin
            n_fail++; $display("FAIL lhu_value: got %h want 00008001", load_data);
        end
        run_txn(1'b0, 3'b010, 32'h0000_0010, 32'd0, 3, 2, 32'h8765_4321, 1'b1);
    endtask

    task automatic test_misaligned();
        run_txn(1'b0, 3'b010, 32'h0000_0002, 32'd0, 0, 0, 32'd0, 1'b0);
        run_txn(1'b1, 3'b100, 32'h0000_0000, 32'h1111_1111, 0, 0, 32'd0, 1'b0);
        run_txn(1'b1, 3'b001, 32'h0000_0005, 32'h1111_1111, 0, 0, 32'd0, 1'b0);
        run_txn(1'b0, 3'b111, 32'h0000_0008, 32'd0, 0, 0, 32'd0, 1'b0);
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 3'b010, 32'h0000_0040, 32'd0, TMO, 0, 32'd0, 1'b1);     // gnt never comes
        run_txn(1'b0, 3'b010, 32'h0000_0044, 32'd0, 0, 0, 32'h5A5A_1234, 1'b0); // recovers
        run_txn(1'b0, 3'b000, 32'h0000_0045, 32'd0, 0, TMO, 32'd0, 1'b0);     // rvalid never comes
        run_txn(1'b1, 3'b010, 32'h0000_0048, 32'h0BAD_F00D, TMO, 0, 32'd0, 1'b0);
        run_txn(1'b0, 3'b001, 32'h0000_004A, 32'd0, TMO - 1, TMO - 1, 32'hFEDC_7654, 1'b1); // last-chance events
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 200; i++) begin
            int g = ($urandom_range(0, 19) == 0) ? $urandom_range(TMO - 1, TMO) : $urandom_range(0, 3);
            int r = ($urandom_range(0, 19) == 0) ? $urandom_range(TMO - 1, TMO) : $urandom_range(0, 3);
            run_txn(1'($urandom), 3'($urandom), $urandom, $urandom, g, r, $urandom, 1'($urandom));
            if ($urandom_range(0, 2) == 0) step();
        end
    endtask

    task automatic test_reset_in_wait();
        lsu_valid = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_0080;
        step();
        lsu_valid = 1'b0; bus_gnt = 1'b1;
        step();
        bus_gnt = 1'b0;
        n_cmp++;
        if ({lsu_busy, bus_req} !== 2'b10) begin
            n_fail++; $display("FAIL wait_before_reset: got busy/req=%b%b want 10", lsu_busy, bus_req);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({lsu_busy, load_data_valid, load_data, store_done, misaligned, bus_error, bus_req,
             bus_we, bus_addr, bus_wdata, bus_be} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%b ld=%h addr=%h wdata=%h be=%b want all zero",
                     lsu_busy, load_data, bus_addr, bus_wdata, bus_be);
        end
        @(negedge clk) rst_n = 1'b1;
        step();
        bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        step();
        bus_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({load_data_valid, lsu_busy, load_data} !== {2'b00, 32'd0}) begin
                n_fail++;
                $display("FAIL late_rvalid_cycle%0d: got ldv/busy/ld=%b%b/%h want 00/00000000",
                         k, load_data_valid, lsu_busy, load_data);
            end
            step();
        end
        last_load = 32'd0;
    endtask

    initial begin
        test_reset();
        test_store_sb();
        test_loads();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Initiator side of the data-memory interface. It accepts one load or store per transaction from the memory stage and drives a req/gnt/rvalid bus to the data memory. It generates byte-lane strobes and replicated store data for sb/sh/sw, and sign- or zero-extends lb/lbu/lh/lhu/lw responses. It stalls the pipeline while a transaction is outstanding, flags misaligned or illegal accesses, and times out a hung bus.

Parameters:
ADDRESS_WIDTH, 32, byte address width
DATA_WIDTH, 32, data width (fixed to 32 for lane logic)
TIMEOUT, 16, max cycles waiting for gnt or rvalid before bus_error

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
lsu_valid  input  1  request present from memory stage
mem_write  input  1  1 = store, 0 = load
funct3  input  3  access size/sign (000 b, 001 h, 010 w, 100 bu, 101 hu)
addr  input  ADDRESS_WIDTH  byte address
store_data  input  DATA_WIDTH  store source register value
lsu_busy  output  1  stall; high whenever state != IDLE
load_data_valid  output  1  one-cycle pulse, load_data valid
load_data  output  DATA_WIDTH  extended load result, held until next load completes
store_done  output  1  one-cycle pulse on store completion
misaligned  output  1  one-cycle pulse, request rejected
bus_error  output  1  one-cycle pulse, timeout abort
bus_req  output  1  bus request
bus_we  output  1  bus write enable
bus_addr  output  ADDRESS_WIDTH  word-aligned address {addr[hi:2],2'b00}
bus_wdata  output  DATA_WIDTH  lane-replicated store data
bus_be  output  4  byte enables
bus_gnt  input  1  memory accepts request this cycle
bus_rvalid  input  1  read data valid
bus_rdata  input  DATA_WIDTH  read word

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, including load_data, bus_addr, bus_wdata and bus_be. An outstanding bus_req drops immediately. A late rvalid after reset is ignored.
- States: IDLE, REQ, WAIT_R, DONE.
- IDLE: request is accepted when lsu_valid=1. All request fields are latched on acceptance.
  - Illegal request: loads with funct3 in {011,110,111}; stores with funct3 not in {000,001,010}.
  - Misaligned request: h/hu/sh with addr[0]=1; w/sw with addr[1:0]!=00.
  - An illegal or misaligned request pulses misaligned the next cycle, stays in IDLE and issues no bus activity (lsu_busy stays 0).
  - A legal request goes to REQ.
- REQ: bus_req=1. bus_we, bus_addr, bus_wdata and bus_be are driven from latched fields and stay stable until gnt.
  - On bus_gnt: a store goes to DONE; a load goes to WAIT_R.
  - bus_req drops the cycle after gnt.
- WAIT_R: on bus_rvalid, bus_rdata is captured, extracted and extended into load_data, then DONE.
  - rvalid in REQ, or in the same cycle as gnt, is ignored; memory responds at least one cycle after gnt.
- DONE: pulses load_data_valid (load) or store_done (store) for one cycle, then IDLE. lsu_busy=0 from the IDLE cycle on.
- Timeout: counter clears on entry to REQ and WAIT_R and increments each cycle in those states. When it reaches TIMEOUT-1 without the awaited event: pulse bus_error, drop bus_req, go to IDLE. No data is updated.
- Store lanes (o = addr[1:0]):
  - sb: be = 1<<o; wdata = byte replicated ×4.
  - sh: be = 0011 (addr[1]=0) or 1100 (addr[1]=1); wdata = half replicated ×2.
  - sw: be = 1111; wdata = store_data.
- Load extraction:
  - lb/lbu: byte at lane o.
  - lh/lhu: half at addr[1].
  - lw: full word.
  - Sign extension uses the MSB of the selected byte or half, not of the word.
- Latency with gnt and rvalid at earliest:
  - Store: accept c0, REQ+gnt c1, store_done c2.
  - Load: accept c0, REQ+gnt c1, rvalid c2, load_data_valid c3.
- lsu_valid is ignored while busy. The pipeline holds its request until lsu_busy falls.

Test Plan:
- sb addr=0x1003, store_data=0x000000A5, gnt at first REQ cycle -> bus_addr=0x1000, be=1000, wdata=0xA5A5A5A5, store_done pulse 2 cycles after accept.
- lb addr=0x0002, rdata=0x00801234 one cycle after gnt -> load_data=0xFFFFFF80, load_data_valid 3 cycles after accept. Repeat with lbu -> 0x00000080.
- lh addr=0x0006, rdata=0x8001FFFF -> load_data=0xFFFF8001. lhu -> 0x00008001.
- lw addr=0x0002 -> misaligned pulse, bus_req never asserted, lsu_busy stays 0. Repeat for store funct3=100 -> misaligned.
- Load with gnt held low for TIMEOUT cycles -> bus_error pulse, bus_req drops, state IDLE, load_data unchanged. Next request completes normally.
- Assert rst_n=0 while in WAIT_R -> all outputs 0 immediately. A subsequent rvalid produces no load_data_valid.
